can_rx_frame_decoder: RTL and testbench
=======================================

Name: can_rx_frame_decoder

Overview:
- Parametrised successor to the CAN frame-maker FSM.
- Decodes the sampled CAN bit stream into complete frames, base (11-bit) or extended (29-bit) ID.
- Adds what the frame maker lacks: bit de-stuffing, CRC-15 check, error detection and a frame-valid handshake.
- Sits after the bit-timing/sample-point logic; feeds the message buffer/filter stage.

Parameters:
MAX_BYTES, 8, data-field capacity in bytes (1..8); received data beyond this is discarded but still CRC-checked.
RECOVER_BITS, 11, consecutive recessive bits required to leave ERROR.
INT_BITS, 3, intermission length in bits.

Ports:
SP  in  1  clock; one rising edge per sampled bit.
reset  in  1  synchronous, active-high.
RX  in  1  sampled bus level (0 = dominant).
frame_valid  out  1  one-cycle pulse: frame accepted, field outputs stable.
IDE  out  1  1 = extended frame.
RTR  out  1  remote frame.
IDF  out  29  identifier; base ID in [10:0], upper bits 0 for base frames.
DLC  out  4  raw DLC as received.
DATA  out  8*MAX_BYTES  byte 0 in [7:0]; unreceived bytes are 0.
err_stuff  out  1  one-cycle pulse: stuff error.
err_crc  out  1  one-cycle pulse: CRC mismatch.
err_form  out  1  one-cycle pulse: dominant CRC delimiter, ACK delimiter or EOF bit.
F_OVRLD  out  1  active-low, one cycle: overload detected in intermission.
busy  out  1  high from SOF until return to IDLE.
tx_ack  out  1  ACK drive (see Optional Feature).

Behaviour:
- Interface: one clock SP; reset synchronous, active-high.
- Reset values: all outputs 0 except F_OVRLD=1 and tx_ack=1. State = IDLE, counters 0, CRC register 0.
- States: IDLE, ID_A(11), RTR_SRR, IDE_BIT, ID_B(18), RTR_EXT, R1, R0, DLC_S(4), DATA_S, CRC_S(15), CRC_DEL, ACK_SLOT, ACK_DEL, EOF_S(7), INTER, ERROR.
- IDLE: RX=0 is SOF; go to ID_A.
- ID_A → RTR_SRR → IDE_BIT.
  - IDE=0: the RTR_SRR bit is RTR; go to R0.
  - IDE=1: go to ID_B → RTR_EXT → R1 → R0.
- R0 → DLC_S.
- After DLC_S:
  - RTR=1 or DLC=0: go to CRC_S.
  - Otherwise DATA_S for 8*min(DLC,8) bits (DLC>8 treated as 8), then CRC_S.
- All fields are shifted MSB-first.
- De-stuffing applies from SOF through the last CRC bit.
  - After 5 equal consecutive bits, the next bit is a stuff bit: not counted and not fed to CRC or fields.
  - A stuff bit equal to the previous bit raises err_stuff.
  - The run count restarts at 1 after a stuff bit, counting the stuff bit's value.
- CRC-15, polynomial 0x4599, init 0, runs over de-stuffed SOF..last data bit.
  - At CRC_S end, the received 15 bits are compared; a mismatch latches crc_bad.
  - err_crc pulses on the cycle after ACK_DEL is sampled, and the decoder goes to ERROR.
- CRC_DEL, ACK_DEL and every EOF bit must be recessive. A dominant value pulses err_form and goes to ERROR.
- ACK_SLOT value is ignored.
- EOF_S: on the 7th recessive EOF bit, pulse frame_valid and update IDE/RTR/IDF/DLC/DATA on the same edge, then go to INTER.
  - Field outputs hold until the next frame_valid; they are never updated on an errored frame.
- INTER lasts INT_BITS bits, then IDLE.
  - Dominant in intermission bit 1 or 2: F_OVRLD low for one cycle, go to ERROR.
  - Dominant in the last bit: treated as SOF, go to ID_A.
- ERROR: wait for RECOVER_BITS consecutive recessive bits (a dominant bit restarts the count), then IDLE.
- Only one error pulse per frame; priority is stuff > form > crc.
- Reset asserted mid-frame: abort immediately, no pulses.
- busy is 0 only in IDLE.

Optional Feature:
- Macro: CAN_RX_ACK_DRIVE_EN.
- Defined: tx_ack=0 during ACK_SLOT when the frame had no stuff error and the CRC matched; 1 otherwise.
- Not defined: tx_ack is constant 1 and no ACK logic is built.

Test Plan:
- Base data frame, ID=0x123, DLC=2, data 0xA5,0x3C, correct CRC and stuffing → frame_valid at EOF bit 7; IDF=0x123, IDE=0, DLC=2, DATA[15:0]=0x3CA5.
- Extended remote frame, ID=0x1ABCDEF0, DLC=4 → frame_valid; IDE=1, RTR=1, IDF=0x1ABCDEF0, DATA=0.
- Six equal bits inside the ID (stuff bit missing) → err_stuff one pulse, no frame_valid, recovery after 11 recessive bits, then SOF decoded normally.
- Valid frame with one CRC bit flipped → err_crc one pulse after ACK_DEL; previous outputs unchanged. With CAN_RX_ACK_DRIVE_EN, tx_ack stays 1.
- Dominant CRC delimiter → err_form; dominant at intermission bit 1 → F_OVRLD low one cycle.
- DLC=15 with MAX_BYTES=4 → 64 data bits consumed, DATA holds bytes 0..3, DLC output=15, frame_valid. Reset mid-DATA → all outputs at reset values, busy=0.

Source files
------------

// File: rtl/can_rx_frame_decoder.sv
// CAN receive frame decoder: de-stuffing, CRC-15 check, error detection and frame-valid handshake.
// Optional ACK drive logic is built only when CAN_RX_ACK_DRIVE_EN is defined.
module can_rx_frame_decoder #(
    parameter int MAX_BYTES    = 8,
    parameter int RECOVER_BITS = 11,
    parameter int INT_BITS     = 3
) (
    input  logic                   SP,
    input  logic                   reset,
    input  logic                   RX,
    output logic                   frame_valid,
    output logic                   IDE,
    output logic                   RTR,
    output logic [28:0]            IDF,
    output logic [3:0]             DLC,
    output logic [8*MAX_BYTES-1:0] DATA,
    output logic                   err_stuff,
    output logic                   err_crc,
    output logic                   err_form,
    output logic                   F_OVRLD,
    output logic                   busy,
    output logic                   tx_ack
);

    typedef enum logic [4:0] {
        IDLE, ID_A, RTR_SRR, IDE_BIT, ID_B, RTR_EXT, R1, R0, DLC_S, DATA_S,
        CRC_S, CRC_DEL, ACK_SLOT, ACK_DEL, EOF_S, INTER, ERROR
    } state_t;

    state_t state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [2:0]  run_reg, run_next;
    logic        last_reg, last_next;
    logic [14:0] crc_reg, crc_next;
    logic [14:0] crc_rx_reg, crc_rx_next;
    logic        crc_bad_reg, crc_bad_next;
    logic [28:0] id_reg, id_next;
    logic        ide_reg, ide_next;
    logic        rtr_reg, rtr_next;
    logic [3:0]  dlc_reg, dlc_next;
    logic [7:0]  nbits_reg, nbits_next;
    logic [8*MAX_BYTES-1:0] data_reg, data_next;

    logic        frame_valid_reg, valid_next;
    logic        err_stuff_reg, err_stuff_next;
    logic        err_form_reg, err_form_next;
    logic        err_crc_reg, err_crc_next;
    logic        ovrld_reg, ovrld_next;
    logic        ide_out_reg, rtr_out_reg;
    logic [28:0] idf_out_reg;
    logic [3:0]  dlc_out_reg;
    logic [8*MAX_BYTES-1:0] data_out_reg;

    logic        destuff_active, bit_ok, sof, data_we, sof_clear;
    logic        crc_fb;
    logic [14:0] crc_step;
    logic [3:0]  dlc_full;

    assign crc_fb   = RX ^ crc_reg[14];
    assign crc_step = {crc_reg[13:0], 1'b0} ^ (crc_fb ? 15'h4599 : 15'h0000);
    assign dlc_full = {dlc_reg[2:0], RX};

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        run_next       = run_reg;
        last_next      = last_reg;
        crc_next       = crc_reg;
        crc_rx_next    = crc_rx_reg;
        crc_bad_next   = crc_bad_reg;
        id_next        = id_reg;
        ide_next       = ide_reg;
        rtr_next       = rtr_reg;
        dlc_next       = dlc_reg;
        nbits_next     = nbits_reg;
        valid_next     = 1'b0;
        err_stuff_next = 1'b0;
        err_form_next  = 1'b0;
        err_crc_next   = 1'b0;
        ovrld_next     = 1'b1;
        data_we        = 1'b0;
        sof_clear      = 1'b0;
        sof            = 1'b0;
        bit_ok         = 1'b1;

        // A stuff bit can still follow the last CRC bit, so CRC_DEL joins the stuffed region when a run is pending.
        destuff_active = (state_reg inside {ID_A, RTR_SRR, IDE_BIT, ID_B, RTR_EXT, R1, R0,
                                            DLC_S, DATA_S, CRC_S})
                         || (state_reg == CRC_DEL && run_reg == 3'd5);
        if (destuff_active) begin
            if (run_reg == 3'd5) begin
                bit_ok = 1'b0;
                if (RX == last_reg) begin
                    err_stuff_next = 1'b1;
                    state_next     = ERROR;
                end else begin
                    run_next  = 3'd1;
                    last_next = RX;
                end
            end else begin
                run_next  = (RX == last_reg) ? run_reg + 3'd1 : 3'd1;
                last_next = RX;
            end
        end

        if (bit_ok) begin
            case (state_reg)
                IDLE: sof = ~RX;
                ID_A: begin
                    crc_next = crc_step;
                    id_next  = {id_reg[27:0], RX};
                    if (cnt_reg == 8'd10) begin
                        state_next = RTR_SRR;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                RTR_SRR: begin
                    crc_next   = crc_step;
                    rtr_next   = RX;
                    state_next = IDE_BIT;
                end
                IDE_BIT: begin
                    crc_next   = crc_step;
                    ide_next   = RX;
                    state_next = RX ? ID_B : R0;
                    cnt_next   = '0;
                end
                ID_B: begin
                    crc_next = crc_step;
                    id_next  = {id_reg[27:0], RX};
                    if (cnt_reg == 8'd17) begin
                        state_next = RTR_EXT;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                RTR_EXT: begin
                    crc_next   = crc_step;
                    rtr_next   = RX;
                    state_next = R1;
                end
                R1: begin
                    crc_next   = crc_step;
                    state_next = R0;
                end
                R0: begin
                    crc_next   = crc_step;
                    state_next = DLC_S;
                    cnt_next   = '0;
                end
                DLC_S: begin
                    crc_next = crc_step;
                    dlc_next = dlc_full;
                    if (cnt_reg == 8'd3) begin
                        nbits_next = dlc_full[3] ? 8'd64 : {2'b00, dlc_full[2:0], 3'b000};
                        state_next = (rtr_reg || dlc_full == 4'd0) ? CRC_S : DATA_S;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                DATA_S: begin
                    crc_next = crc_step;
                    data_we  = 1'b1;
                    if (cnt_reg == nbits_reg - 8'd1) begin
                        state_next = CRC_S;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                CRC_S: begin
                    crc_rx_next = {crc_rx_reg[13:0], RX};
                    if (cnt_reg == 8'd14) begin
                        crc_bad_next = ({crc_rx_reg[13:0], RX} != crc_reg);
                        state_next   = CRC_DEL;
                        cnt_next     = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                CRC_DEL: begin
                    if (!RX) begin
                        err_form_next = 1'b1;
                        state_next    = ERROR;
                    end else state_next = ACK_SLOT;
                end
                ACK_SLOT: state_next = ACK_DEL;
                ACK_DEL: begin
                    if (!RX) begin
                        err_form_next = 1'b1;
                        state_next    = ERROR;
                    end else if (crc_bad_reg) begin
                        err_crc_next = 1'b1;
                        state_next   = ERROR;
                    end else begin
                        state_next = EOF_S;
                        cnt_next   = '0;
                    end
                end
                EOF_S: begin
                    if (!RX) begin
                        err_form_next = 1'b1;
                        state_next    = ERROR;
                    end else if (cnt_reg == 8'd6) begin
                        valid_next = 1'b1;
                        state_next = INTER;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                INTER: begin
                    if (!RX) begin
                        if (cnt_reg == 8'(INT_BITS - 1)) sof = 1'b1;
                        else begin
                            ovrld_next = 1'b0;
                            state_next = ERROR;
                        end
                    end else if (cnt_reg == 8'(INT_BITS - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                ERROR: begin
                    if (!RX) cnt_next = '0;
                    else if (cnt_reg == 8'(RECOVER_BITS - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else cnt_next = cnt_reg + 8'd1;
                end
                default: state_next = IDLE;
            endcase
        end

        // SOF is a dominant bit fed into a zero CRC register, so the register simply stays zero.
        if (sof) begin
            state_next   = ID_A;
            cnt_next     = '0;
            run_next     = 3'd1;
            last_next    = 1'b0;
            crc_next     = '0;
            crc_bad_next = 1'b0;
            id_next      = '0;
            ide_next     = 1'b0;
            rtr_next     = 1'b0;
            dlc_next     = '0;
            sof_clear    = 1'b1;
        end

        if (state_next == ERROR && state_reg != ERROR) cnt_next = '0;
    end

    // Bytes past MAX_BYTES have no lane and are dropped; they were already fed to the CRC.
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
        assign data_next[gi*8 +: 8] = sof_clear ? 8'h00 :
                                      (data_we && cnt_reg[5:3] == 3'(gi)) ? {data_reg[gi*8 +: 7], RX} :
                                      data_reg[gi*8 +: 8];
    end

    always_ff @(posedge SP) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            run_reg         <= '0;
            last_reg        <= 1'b0;
            crc_reg         <= '0;
            crc_rx_reg      <= '0;
            crc_bad_reg     <= 1'b0;
            id_reg          <= '0;
            ide_reg         <= 1'b0;
            rtr_reg         <= 1'b0;
            dlc_reg         <= '0;
            nbits_reg       <= '0;
            data_reg        <= '0;
            frame_valid_reg <= 1'b0;
            err_stuff_reg   <= 1'b0;
            err_form_reg    <= 1'b0;
            err_crc_reg     <= 1'b0;
            ovrld_reg       <= 1'b1;
            ide_out_reg     <= 1'b0;
            rtr_out_reg     <= 1'b0;
            idf_out_reg     <= '0;
            dlc_out_reg     <= '0;
            data_out_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            run_reg         <= run_next;
            last_reg        <= last_next;
            crc_reg         <= crc_next;
            crc_rx_reg      <= crc_rx_next;
            crc_bad_reg     <= crc_bad_next;
            id_reg          <= id_next;
            ide_reg         <= ide_next;
            rtr_reg         <= rtr_next;
            dlc_reg         <= dlc_next;
            nbits_reg       <= nbits_next;
            data_reg        <= data_next;
            frame_valid_reg <= valid_next;
            err_stuff_reg   <= err_stuff_next;
            err_form_reg    <= err_form_next;
            err_crc_reg     <= err_crc_next;
            ovrld_reg       <= ovrld_next;
            if (valid_next) begin
                ide_out_reg  <= ide_reg;
                rtr_out_reg  <= rtr_reg;
                idf_out_reg  <= id_reg;
                dlc_out_reg  <= dlc_reg;
                data_out_reg <= data_reg;
            end
        end
    end

    assign frame_valid = frame_valid_reg;
    assign IDE         = ide_out_reg;
    assign RTR         = rtr_out_reg;
    assign IDF         = idf_out_reg;
    assign DLC         = dlc_out_reg;
    assign DATA        = data_out_reg;
    assign err_stuff   = err_stuff_reg;
    assign err_form    = err_form_reg;
    assign err_crc     = err_crc_reg;
    assign F_OVRLD     = ovrld_reg;
    assign busy        = (state_reg != IDLE);

`ifdef CAN_RX_ACK_DRIVE_EN
    // Reaching ACK_SLOT already implies no stuff error, so only the CRC result gates the ACK.
    assign tx_ack = !(state_reg == ACK_SLOT && !crc_bad_reg);
`else
    assign tx_ack = 1'b1;
`endif

endmodule

// File: tb/tb_can_rx_frame_decoder.sv
// Directed bench for can_rx_frame_decoder: builds stuffed CAN frames with CRC and checks decoded fields and error pulses.
module tb_can_rx_frame_decoder;
    localparam int MB = 4;
`ifdef CAN_RX_ACK_DRIVE_EN
    localparam int ACK_LO = 1;
`else
    localparam int ACK_LO = 0;
`endif

    logic          SP = 1'b0;
    logic          reset = 1'b1;
    logic          RX = 1'b1;
    logic          frame_valid, IDE, RTR, err_stuff, err_crc, err_form, F_OVRLD, busy, tx_ack;
    logic [28:0]   IDF;
    logic [3:0]    DLC;
    logic [8*MB-1:0] DATA;

    can_rx_frame_decoder #(.MAX_BYTES(MB), .RECOVER_BITS(11), .INT_BITS(3)) dut (
        .SP(SP), .reset(reset), .RX(RX), .frame_valid(frame_valid), .IDE(IDE), .RTR(RTR),
        .IDF(IDF), .DLC(DLC), .DATA(DATA), .err_stuff(err_stuff), .err_crc(err_crc),
        .err_form(err_form), .F_OVRLD(F_OVRLD), .busy(busy), .tx_ack(tx_ack)
    );

    always #5 SP = ~SP;

    int checks = 0;
    int failures = 0;
    logic raw_q[$];
    logic stream_q[$];
    int fv_cnt, fv_at, es_cnt, es_at, ef_cnt, ef_at, ec_cnt, ec_at, ov_cnt, ov_at, ack_lo_cnt;
    int crcdel_idx, ackdel_idx, eof7_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic push_raw(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) raw_q.push_back(v[i]);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) stream_q.push_back(1'b1);
    endtask

    // Appends one transmitted frame (stuffed SOF..CRC, then delimiters, ACK and EOF) to stream_q.
    task automatic build_frame(input logic ext, input logic rtr, input logic [28:0] id,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input int crc_flip, input logic crc_del);
        logic [14:0] crc;
        logic fb;
        logic last;
        int run;
        int nb;
        raw_q.delete();
        raw_q.push_back(1'b0);
        if (!ext) begin
            push_raw(32'(id[10:0]), 11);
            raw_q.push_back(rtr);
            raw_q.push_back(1'b0);
            raw_q.push_back(1'b0);
        end else begin
            push_raw(32'(id[28:18]), 11);
            raw_q.push_back(1'b1);
            raw_q.push_back(1'b1);
            push_raw(32'(id[17:0]), 18);
            raw_q.push_back(rtr);
            raw_q.push_back(1'b0);
            raw_q.push_back(1'b0);
        end
        push_raw(32'(dlc), 4);
        nb = (dlc > 4'd8) ? 8 : int'(dlc);
        if (!rtr) for (int i = 0; i < nb; i++) push_raw(32'(data[i*8 +: 8]), 8);
        crc = '0;
        foreach (raw_q[i]) begin
            fb  = raw_q[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
        push_raw(32'(crc), 15);
        run  = 0;
        last = 1'b1;
        foreach (raw_q[i]) begin
            stream_q.push_back(raw_q[i]);
            if (run > 0 && raw_q[i] == last) run++;
            else run = 1;
            last = raw_q[i];
            if (run == 5) begin
                stream_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        crcdel_idx = stream_q.size();
        stream_q.push_back(crc_del);
        stream_q.push_back(1'b0);
        ackdel_idx = stream_q.size();
        stream_q.push_back(1'b1);
        repeat (7) stream_q.push_back(1'b1);
        eof7_idx = stream_q.size() - 1;
    endtask

    task automatic send_stream();
        fv_cnt = 0; fv_at = -1; es_cnt = 0; es_at = -1; ef_cnt = 0; ef_at = -1;
        ec_cnt = 0; ec_at = -1; ov_cnt = 0; ov_at = -1; ack_lo_cnt = 0;
        foreach (stream_q[i]) begin
            RX = stream_q[i];
            @(posedge SP);
            #1;
            if (frame_valid) begin fv_cnt++; fv_at = i; end
            if (err_stuff)   begin es_cnt++; es_at = i; end
            if (err_form)    begin ef_cnt++; ef_at = i; end
            if (err_crc)     begin ec_cnt++; ec_at = i; end
            if (!F_OVRLD)    begin ov_cnt++; ov_at = i; end
            if (!tx_ack) ack_lo_cnt++;
        end
        stream_q.delete();
        RX = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fv"}, 64'(frame_valid), 64'd0);
        check({tag, "_ide_rtr"}, 64'({IDE, RTR}), 64'd0);
        check({tag, "_idf"}, 64'(IDF), 64'd0);
        check({tag, "_dlc"}, 64'(DLC), 64'd0);
        check({tag, "_data"}, 64'(DATA), 64'd0);
        check({tag, "_errs"}, 64'({err_stuff, err_form, err_crc}), 64'd0);
        check({tag, "_ovrld"}, 64'(F_OVRLD), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_txack"}, 64'(tx_ack), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge SP);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Base data frame
        build_frame(1'b0, 1'b0, 29'h123, 4'd2, 64'h3CA5, -1, 1'b1);
        idle_bits(3);
        send_stream();
        check("base_fv_cnt", 64'(fv_cnt), 64'd1);
        check("base_fv_at", 64'(fv_at), 64'(eof7_idx));
        check("base_idf", 64'(IDF), 64'h123);
        check("base_ide_rtr", 64'({IDE, RTR}), 64'd0);
        check("base_dlc", 64'(DLC), 64'd2);
        check("base_data", 64'(DATA), 64'h3CA5);
        check("base_errs", 64'(es_cnt + ef_cnt + ec_cnt + ov_cnt), 64'd0);
        check("base_ack", 64'(ack_lo_cnt), 64'(ACK_LO));
        check("base_busy", 64'(busy), 64'd0);

        // Extended remote frame
        build_frame(1'b1, 1'b1, 29'h1ABCDEF0, 4'd4, 64'h0, -1, 1'b1);
        idle_bits(3);
        send_stream();
        check("extrtr_fv_cnt", 64'(fv_cnt), 64'd1);
        check("extrtr_ide_rtr", 64'({IDE, RTR}), 64'd3);
        check("extrtr_idf", 64'(IDF), 64'h1ABCDEF0);
        check("extrtr_dlc", 64'(DLC), 64'd4);
        check("extrtr_data", 64'(DATA), 64'd0);

        // Missing stuff bit: SOF plus five zeros of ID
        repeat (6) stream_q.push_back(1'b0);
        idle_bits(10);
        send_stream();
        check("stuff_cnt", 64'(es_cnt), 64'd1);
        check("stuff_at", 64'(es_at), 64'd5);
        check("stuff_other", 64'(fv_cnt + ef_cnt + ec_cnt), 64'd0);
        check("stuff_busy_10", 64'(busy), 64'd1);
        idle_bits(1);
        send_stream();
        check("stuff_busy_11", 64'(busy), 64'd0);
        build_frame(1'b0, 1'b0, 29'h7F0, 4'd1, 64'h0F, -1, 1'b1);
        idle_bits(3);
        send_stream();
        check("recov_fv_cnt", 64'(fv_cnt), 64'd1);
        check("recov_idf", 64'(IDF), 64'h7F0);
        check("recov_data", 64'(DATA), 64'h0F);

        // Flipped CRC bit
        build_frame(1'b0, 1'b0, 29'h456, 4'd1, 64'h99, 0, 1'b1);
        idle_bits(11);
        send_stream();
        check("crc_cnt", 64'(ec_cnt), 64'd1);
        check("crc_at", 64'(ec_at), 64'(ackdel_idx));
        check("crc_other", 64'(fv_cnt + es_cnt + ef_cnt), 64'd0);
        check("crc_hold_idf", 64'(IDF), 64'h7F0);
        check("crc_hold_dlc_data", 64'({DLC, DATA}), {28'd0, 4'd1, 32'h0F});
        check("crc_ack", 64'(ack_lo_cnt), 64'd0);
        check("crc_busy", 64'(busy), 64'd0);

        // Dominant CRC delimiter
        build_frame(1'b0, 1'b0, 29'h321, 4'd1, 64'h42, -1, 1'b0);
        idle_bits(11);
        send_stream();
        check("form_cnt", 64'(ef_cnt), 64'd1);
        check("form_at", 64'(ef_at), 64'(crcdel_idx));
        check("form_other", 64'(fv_cnt + es_cnt + ec_cnt), 64'd0);

        // Overload at intermission bit 1
        build_frame(1'b0, 1'b0, 29'h0AA, 4'd0, 64'h0, -1, 1'b1);
        stream_q.push_back(1'b0);
        idle_bits(11);
        send_stream();
        check("ovr_fv_cnt", 64'(fv_cnt), 64'd1);
        check("ovr_cnt", 64'(ov_cnt), 64'd1);
        check("ovr_at", 64'(ov_at), 64'(eof7_idx + 1));
        check("ovr_idf_dlc", 64'({IDF, DLC}), {31'd0, 29'h0AA, 4'd0});
        check("ovr_busy", 64'(busy), 64'd0);

        // SOF in the last intermission bit
        build_frame(1'b0, 1'b0, 29'h111, 4'd1, 64'h11, -1, 1'b1);
        idle_bits(2);
        build_frame(1'b1, 1'b0, 29'h00012345, 4'd3, 64'h332211, -1, 1'b1);
        idle_bits(3);
        send_stream();
        check("b2b_fv_cnt", 64'(fv_cnt), 64'd2);
        check("b2b_fv_at", 64'(fv_at), 64'(eof7_idx));
        check("b2b_idf", 64'(IDF), 64'h12345);
        check("b2b_ide_rtr", 64'({IDE, RTR}), 64'd2);
        check("b2b_data", 64'(DATA), 64'h332211);

        // DLC=15 with four-byte capacity
        build_frame(1'b0, 1'b0, 29'h2A5, 4'd15, 64'h8877665544332211, -1, 1'b1);
        idle_bits(3);
        send_stream();
        check("dlc15_fv_at", 64'(fv_at), 64'(eof7_idx));
        check("dlc15_dlc", 64'(DLC), 64'd15);
        check("dlc15_data", 64'(DATA), 64'h44332211);
        check("dlc15_idf", 64'(IDF), 64'h2A5);

        // Reset in the middle of the data field
        build_frame(1'b0, 1'b0, 29'h3C3, 4'd8, 64'hFFEEDDCCBBAA9988, -1, 1'b1);
        while (stream_q.size() > 30) void'(stream_q.pop_back());
        send_stream();
        check("midrst_busy_before", 64'(busy), 64'd1);
        check("midrst_pulses", 64'(fv_cnt + es_cnt + ef_cnt + ec_cnt), 64'd0);
        reset = 1'b1;
        @(posedge SP);
        #1;
        check_reset_outputs("midrst");
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
